// File: rtl/snoop_ctrl.sv
// Snoop-cycle sequencer for the L1 tag/status array: captures EADS, looks up the
// tag, reports PHIT/PHITM, streams out a dirty line, and updates the MESI state.
module snoop_ctrl #(
    parameter int AW      = 32,
    parameter int BEATS   = 4,
    parameter int MAXHOLD = 8,
    localparam int BW     = $clog2(BEATS),
    localparam int HW     = $clog2(MAXHOLD + 1)
) (
    input  logic          SCLK,
    input  logic          SRST,
    input  logic          EADS,
    input  logic          SNP_RW,
    input  logic [AW-1:0] SNP_ADDR,
    input  logic          CPU_REQ,
    output logic          CPU_GNT,
    output logic          TAG_REQ,
    output logic [AW-1:0] TAG_ADDR,
    input  logic          TAG_HIT,
    input  logic [1:0]    TAG_STATUS,
    output logic          STAT_WE,
    output logic [1:0]    STAT_NEW,
    output logic          WB_VALID,
    input  logic          WB_READY,
    output logic [BW-1:0] WB_BEAT,
    output logic          PHIT,
    output logic          PHITM,
    output logic          PINV,
    output logic          SNP_DONE,
    output logic          SNP_OVF,
    output logic          BUSY,
    output logic [2:0]    DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_SAMPLE = 3'd2,
        S_RESP   = 3'd3,
        S_WB     = 3'd4,
        S_UPDATE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_pend;
    logic            r_rw;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_status;
    logic            r_phit;
    logic            r_phitm;
    logic [BW-1:0]   r_beat;
    logic            r_gnt;
    logic [HW-1:0]   r_hold;
    logic            r_ovf;
    logic            w_busy;
    logic            w_capture;
    logic            w_last_beat;

    assign w_busy      = r_pend | (r_state != S_IDLE);
    assign w_capture   = EADS & ~w_busy;
    assign w_last_beat = (r_beat == BW'(BEATS - 1));

    always_ff @(posedge SCLK) begin
        if (SRST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // A snoop only takes the tag port once the processor has released it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_pend && !r_gnt) w_next = S_LOOKUP;
            S_LOOKUP: w_next = S_SAMPLE;
            S_SAMPLE: w_next = S_RESP;
            S_RESP:   w_next = r_phitm ? S_WB : S_UPDATE;
            S_WB:     if (WB_READY && w_last_beat) w_next = S_UPDATE;
            S_UPDATE: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge SCLK) begin
        if (SRST) begin
            r_pend   <= 1'b0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_status <= 2'b00;
            r_phit   <= 1'b0;
            r_phitm  <= 1'b0;
            r_beat   <= '0;
            r_gnt    <= 1'b0;
            r_hold   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= EADS & w_busy;

            if (w_capture) begin
                r_pend <= 1'b1;
                r_rw   <= SNP_RW;
                r_addr <= SNP_ADDR;
            end else if (r_state == S_DONE) begin
                r_pend <= 1'b0;
            end

            if (r_state == S_IDLE && w_next == S_LOOKUP) begin
                r_phit  <= 1'b0;
                r_phitm <= 1'b0;
            end else if (r_state == S_SAMPLE) begin
                // A hit reporting state I is a miss.
                r_status <= TAG_STATUS;
                r_phit   <= TAG_HIT && (TAG_STATUS != 2'b00);
                r_phitm  <= TAG_HIT && (TAG_STATUS == 2'b11);
            end

            if (r_state == S_WB && WB_READY) r_beat <= r_beat + 1'b1;

            if (r_state != S_IDLE) begin
                r_gnt  <= 1'b0;
                r_hold <= '0;
            end else if (!r_pend) begin
                r_gnt  <= CPU_REQ;
                r_hold <= '0;
            end else if (r_gnt) begin
                // Processor keeps the port for at most MAXHOLD cycles once a snoop waits.
                if (!CPU_REQ || r_hold == HW'(MAXHOLD - 1)) begin
                    r_gnt  <= 1'b0;
                    r_hold <= '0;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end else begin
                r_hold <= '0;
            end
        end
    end

    always_comb begin
        STAT_WE  = 1'b0;
        STAT_NEW = 2'b00;
        PINV     = 1'b0;
        if (r_state == S_UPDATE && r_phit) begin
            if (!r_rw) begin
                STAT_WE  = 1'b1;
                STAT_NEW = 2'b00;
                PINV     = 1'b1;
            end else if (r_status[1]) begin
                STAT_WE  = 1'b1;
                STAT_NEW = 2'b01;
            end
        end
    end

    assign CPU_GNT   = r_gnt;
    assign TAG_REQ   = (r_state == S_LOOKUP);
    assign TAG_ADDR  = r_addr;
    assign WB_VALID  = (r_state == S_WB);
    assign WB_BEAT   = r_beat;
    assign PHIT      = r_phit;
    assign PHITM     = r_phitm;
    assign SNP_DONE  = (r_state == S_DONE);
    assign SNP_OVF   = r_ovf;
    assign BUSY      = w_busy;
    assign DBG_STATE = r_state;

endmodule

// File: doc/snoop_ctrl.md
Name: snoop_ctrl

Overview:
- Sequences one external snoop cycle against the L1 cache tag/status array: latches the snoop strobe, looks up the tag, and reports hit or hit-modified.
- On a modified hit it streams the dirty line out as a writeback. It then writes the new MESI state: 00=I, 01=S, 10=E, 11=M.
- Also arbitrates the single tag port between the processor and snoop cycles.
- Sits between the external bus interface and the cache tag array. It is the sequencer for the snoop-response logic.

Parameters:
- AW, 32, snoop/tag address width.
- BEATS, 4, writeback beats per line (power of two, >=2).
- MAXHOLD, 8, maximum cycles the processor may keep the tag port while a snoop is pending.

Ports:
- SCLK  in  1  clock, all logic on rising edge.
- SRST  in  1  synchronous active-high reset.
- EADS  in  1  external snoop strobe, one-cycle pulse.
- SNP_RW  in  1  sampled with EADS: 1=read snoop, 0=write snoop (invalidate).
- SNP_ADDR  in  AW  sampled with EADS.
- CPU_REQ  in  1  processor requests the tag port.
- CPU_GNT  out  1  processor owns the tag port.
- TAG_REQ  out  1  tag lookup strobe.
- TAG_ADDR  out  AW  lookup address (latched snoop address).
- TAG_HIT  in  1  valid the cycle after TAG_REQ.
- TAG_STATUS  in  2  line state, valid the cycle after TAG_REQ.
- STAT_WE  out  1  status write strobe.
- STAT_NEW  out  2  new line state.
- WB_VALID  out  1  writeback beat valid.
- WB_READY  in  1  bus accepts the beat.
- WB_BEAT  out  log2(BEATS)  current beat index.
- PHIT  out  1  snoop hit.
- PHITM  out  1  snoop hit on a modified line.
- PINV  out  1  one-cycle pulse: line invalidated.
- SNP_DONE  out  1  one-cycle pulse: snoop complete.
- SNP_OVF  out  1  one-cycle pulse: EADS dropped.
- BUSY  out  1  snoop pending or in progress.

Behaviour:
- Reset: all outputs 0, state IDLE, pending cleared, hold counter 0.
- SRST mid-operation aborts everything, including a writeback; the status write is not performed.
- EADS capture:
  - When no snoop is pending or active, EADS latches SNP_RW/SNP_ADDR and sets pending.
  - An EADS that arrives while pending or active is dropped, and SNP_OVF pulses the next cycle.
- BUSY = pending | (state != IDLE).
- Arbitration in IDLE:
  - No pending snoop: CPU_GNT follows CPU_REQ, registered (1-cycle latency).
  - Pending snoop with CPU_GNT=0: go to LOOKUP next cycle; snoop has priority over a new CPU_REQ in the same cycle.
  - Pending snoop with CPU_GNT=1: the hold counter increments each cycle. CPU_GNT drops when CPU_REQ falls or the counter reaches MAXHOLD, whichever comes first. The counter clears when CPU_GNT falls.
  - CPU_GNT is never 1 outside IDLE.
- State sequence: IDLE -> LOOKUP -> SAMPLE -> RESP -> (WB) -> UPDATE -> DONE -> IDLE.
- LOOKUP: TAG_REQ=1 for one cycle, TAG_ADDR=latched address; PHIT/PHITM cleared.
- SAMPLE: register TAG_HIT/TAG_STATUS. A miss, or a hit with status I, is treated as a miss.
- RESP: PHIT = hit and status in {S,E,M}; PHITM = hit and status M. Both are held until the next LOOKUP. Next state is WB if PHITM, else UPDATE.
- WB:
  - WB_VALID=1 with WB_BEAT starting at 0.
  - A beat completes on WB_VALID & WB_READY, which increments WB_BEAT.
  - WB_READY low stalls with WB_BEAT held; there is no timeout.
  - After beat BEATS-1 completes: WB_VALID=0, WB_BEAT wraps to 0, go to UPDATE.
- UPDATE (one cycle):
  - Miss: no write.
  - Write snoop hit: STAT_WE=1, STAT_NEW=00, PINV=1.
  - Read snoop hit on M or E: STAT_WE=1, STAT_NEW=01.
  - Read snoop hit on S: no write.
- DONE: SNP_DONE=1 for one cycle, pending cleared, return to IDLE. An EADS in this cycle is still dropped.
- Minimum latency from EADS to SNP_DONE is 6 cycles with no CPU ownership and no writeback. Writeback adds at least BEATS cycles.

Test Plan:
- Read snoop on an E line, TAG_STATUS=10, idle CPU -> PHIT=1, PHITM=0, no WB, STAT_WE with STAT_NEW=01, SNP_DONE exactly 6 cycles after EADS.
- Write snoop on an M line, TAG_STATUS=11, WB_READY low for 2 cycles during beat 1 -> PHITM=1, beats 0..3 each accepted once, WB_BEAT held during the stall, then STAT_NEW=00 with PINV=1, then SNP_DONE.
- Snoop miss, TAG_HIT=0 -> PHIT=PHITM=0, STAT_WE never asserted, SNP_DONE asserted.
- CPU holds CPU_REQ=1 continuously, EADS arrives -> CPU_GNT drops after exactly MAXHOLD=8 cycles; LOOKUP follows; CPU_GNT returns only after SNP_DONE.
- Second EADS during a writeback -> SNP_OVF pulse, the latched address is unchanged, and only one SNP_DONE occurs.
- SRST asserted in the WB state at beat 2 -> next cycle all outputs 0, no STAT_WE; a new EADS afterwards completes normally.
